mul_issue_wb: RTL and testbench

// - Issue/writeback wrapper around the 4-stage negedge multiplier for RV32 M-extension MUL/MULH/MULHSU/MULHU.
// - Accepts ops from decode with valid/ready, drives the multiplier operands, and tracks each op in a shadow pipe.
// - Selects and corrects the 32-bit half of the product, then buffers results in a FIFO for the writeback stage.
// - Keeps multiplier throughput at 1 op/cycle; credit-based issue means the pipe never needs to stall.

---
 rtl/mul_issue_wb_if.sv | 31 +++
 rtl/mul_issue_wb.sv | 216 +++++++++++++++++++++
 tb/tb_mul_issue_wb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_wb_if.sv
// Decode, multiplier and writeback signals of the M-extension issue/writeback block.
// The slave modport is the block's view. The master modport is the environment's view.
interface mul_issue_wb_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy_rd;

    modport slave (
        input  flush, req_valid, req_op, req_rs1, req_rs2, req_rd, mul_result, wb_ready,
        output req_ready, mul_start, mul_signed, mul_x, mul_y, wb_valid, wb_rd, wb_data, busy_rd
    );

    modport master (
        output flush, req_valid, req_op, req_rs1, req_rs2, req_rd, mul_result, wb_ready,
        input  req_ready, mul_start, mul_signed, mul_x, mul_y, wb_valid, wb_rd, wb_data, busy_rd
    );
endinterface

// File: rtl/mul_issue_wb.sv
// Issue/writeback wrapper around the negedge pipelined multiplier (RV32 MUL/MULH/MULHSU/MULHU).
// Ops are issued against credits that cover the shadow pipe, the capture register and the result FIFO.
// Because of this, the pipe never stalls and the FIFO cannot overflow.
module mul_issue_wb #(
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FIFO_DEPTH = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mul_issue_wb_if.slave bus
);
    localparam int unsigned STAGES = MUL_LAT + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } op_e;

    // issue side
    op_e                     op;
    logic                    waw;
    logic                    accept;
    logic                    hi_sel_in;
    logic [31:0]             corr_in;
    logic                    mul_start_q;
    logic                    mul_signed_q;
    logic [31:0]             mul_x_q;
    logic [31:0]             mul_y_q;

    // credits and destination scoreboard
    logic [CNT_W-1:0]        credits_q;
    logic [CNT_W-1:0]        credits_d;
    logic [31:0]             busy_q;
    logic [31:0]             busy_d;

    // shadow pipe, one entry per multiplier stage plus the issue slot
    logic [STAGES-1:0]       sh_valid;
    logic [STAGES-1:0]       sh_hi;
    logic [STAGES-1:0][4:0]  sh_rd;
    logic [STAGES-1:0][31:0] sh_corr;

    // capture stage
    logic                    capture;
    logic                    drop;
    logic [31:0]             cap_calc;
    logic                    cap_valid;
    logic [4:0]              cap_rd;
    logic [31:0]             cap_data;

    // result FIFO
    logic [4:0]              fifo_rd   [FIFO_DEPTH];
    logic [31:0]             fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_nonempty;
    logic                    push;
    logic                    pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Accept decision: credit limit, WAW hazard on rd and flush. Held low during reset.
    always_comb begin
        op            = op_e'(bus.req_op);
        waw           = (bus.req_rd != 5'd0) && busy_q[bus.req_rd];
        bus.req_ready = rst_ni && !bus.flush && (credits_q < DEPTH_C) && !waw;
        accept        = bus.req_valid && bus.req_ready;
        hi_sel_in     = (op != OP_MUL);
        corr_in       = (op == OP_MULHSU && bus.req_rs1[31]) ? bus.req_rs2 : '0;
    end

    // Operand registers and the start pulse for the multiplier.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_start_q  <= 1'b0;
            mul_signed_q <= 1'b0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
        end else begin
            mul_start_q <= accept;
            if (accept) begin
                mul_signed_q <= (op == OP_MULH);
                mul_x_q      <= bus.req_rs1;
                mul_y_q      <= bus.req_rs2;
            end
        end
    end

    // Shadow pipe that tracks each issued op alongside the multiplier stages.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_valid <= '0;
            sh_hi    <= '0;
            sh_rd    <= '0;
            sh_corr  <= '0;
        end else begin
            sh_valid <= bus.flush ? '0 : {sh_valid[STAGES-2:0], accept};
            sh_hi    <= {sh_hi[STAGES-2:0], hi_sel_in};
            sh_rd    <= {sh_rd[STAGES-2:0], bus.req_rd};
            sh_corr  <= {sh_corr[STAGES-2:0], corr_in};
        end
    end

    // MULHSU runs as unsigned x unsigned. The high half is fixed by subtracting rs2 when rs1 is negative.
    always_comb begin
        capture  = sh_valid[STAGES-1];
        drop     = capture && (sh_rd[STAGES-1] == 5'd0);
        cap_calc = sh_hi[STAGES-1] ? (bus.mul_result[63:32] - sh_corr[STAGES-1])
                                   : bus.mul_result[31:0];
    end

    // Capture register between the multiplier output and the FIFO.
    // rd=0 results are discarded here.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_valid <= 1'b0;
            cap_rd    <= '0;
            cap_data  <= '0;
        end else begin
            cap_valid <= !bus.flush && capture && !drop;
            if (capture) begin
                cap_rd   <= sh_rd[STAGES-1];
                cap_data <= cap_calc;
            end
        end
    end

    // FIFO handshake terms.
    always_comb begin
        fifo_nonempty = (fifo_cnt != '0);
        push          = cap_valid;
        pop           = fifo_nonempty && bus.wb_ready;
    end

    // In-order result FIFO. Push and pop may occur together at any occupancy.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= cap_rd;
                fifo_data[wr_ptr] <= cap_data;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Next credits and busy map.
    // A credit returns on a pop, or when an rd=0 result is discarded.
    always_comb begin
        credits_d = credits_q + CNT_W'(accept) - CNT_W'(pop) - CNT_W'(drop);
        busy_d    = busy_q;
        if (pop) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (accept && bus.req_rd != 5'd0) begin
            busy_d[bus.req_rd] = 1'b1;
        end
        if (bus.flush) begin
            credits_d = '0;
            busy_d    = '0;
        end
    end

    // Credit counter and destination busy map.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
            busy_q    <= '0;
        end else begin
            credits_q <= credits_d;
            busy_q    <= busy_d;
        end
    end

    // Output drive. The head fields read as zero while the FIFO is empty.
    always_comb begin
        bus.mul_start  = mul_start_q;
        bus.mul_signed = mul_signed_q;
        bus.mul_x      = mul_x_q;
        bus.mul_y      = mul_y_q;
        bus.wb_valid   = fifo_nonempty;
        bus.wb_rd      = fifo_nonempty ? fifo_rd[rd_ptr] : '0;
        bus.wb_data    = fifo_nonempty ? fifo_data[rd_ptr] : '0;
        bus.busy_rd    = busy_q;
    end
endmodule

// File: tb/tb_mul_issue_wb.sv
// Bench for mul_issue_wb. It includes a 4-negedge multiplier model.
// A transaction-level reference tracks the ops that are issued but not yet retired.
module tb_mul_issue_wb;
    localparam int DEPTH = 6;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    mul_issue_wb_if bus ();

    mul_issue_wb #(.MUL_LAT(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Multiplier: samples X/Y every negedge. The product reaches Result four negedges later.
    logic [63:0] mpipe [4];

    function automatic logic [63:0] mprod(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] xe, ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    always @(negedge clk) begin
        mpipe[0] <= mprod(bus.mul_x, bus.mul_y, bus.mul_signed);
        for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_result = mpipe[3];

    // Reference: the architectural result of each op. It uses 66-bit signed arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa, sb, p;
        sa = (op == 2'd3) ? $signed({2'b00, a}) : $signed({{2{a[31]}}, a});
        sb = (op == 2'd1) ? $signed({{2{b[31]}}, b}) : $signed({2'b00, b});
        p  = sa * sb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          t;
    } ent_t;

    ent_t        q[$];
    int          k = 0;
    int          checks = 0;
    int          errors = 0;
    bit          last_acc = 1'b0;
    bit          e_start = 1'b0;
    bit          e_sgn = 1'b0;
    logic [31:0] e_x = '0;
    logic [31:0] e_y = '0;

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) if (q[i].rd != 5'd0) b[q[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the posedge, check before the negedge, then advance the reference.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit wbr, input bit fl);
        bit          e_ready, e_wbv, pop;
        logic [31:0] e_busy;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rd    = rd;
        bus.wb_ready  = wbr;
        bus.flush     = fl;
        #1;
        e_busy  = model_busy();
        e_ready = !fl && (q.size() < DEPTH) && !(rd != 5'd0 && e_busy[rd]);
        e_wbv   = (q.size() > 0) && (q[0].rd != 5'd0) && (k >= q[0].t + 6);
        check("req_ready",  bus.req_ready, e_ready);
        check("wb_valid",   bus.wb_valid, e_wbv);
        check("wb_rd",      bus.wb_rd, e_wbv ? q[0].rd : 5'd0);
        check("wb_data",    bus.wb_data, e_wbv ? q[0].data : 32'd0);
        check("busy_rd",    bus.busy_rd, e_busy);
        check("mul_start",  bus.mul_start, e_start);
        check("mul_signed", bus.mul_signed, e_sgn);
        check("mul_x",      bus.mul_x, e_x);
        check("mul_y",      bus.mul_y, e_y);
        @(negedge clk);
        last_acc = v && e_ready;
        pop      = e_wbv && wbr;
        k++;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].rd == 5'd0 && k >= q[i].t + 5) q.delete(i);
            if (last_acc) q.push_back('{rd, ref_res(op, a, b), k});
        end
        e_start = last_acc;
        if (last_acc) begin
            e_x   = a;
            e_y   = b;
            e_sgn = (op == 2'd1);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit wbr);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, wbr, 1'b0);
    endtask

    task automatic issue_hold(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input bit wbr, input int budget);
        int n;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < budget) begin
            cycle(1'b1, op, a, b, rd, wbr, 1'b0);
            n++;
        end
        if (!last_acc) begin
            checks++;
            errors++;
            $error("FAIL issue_timeout rd=%0d observed=not-accepted expected=accepted", rd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  bus.req_ready, 0);
        check({tag, "_start"},  bus.mul_start, 0);
        check({tag, "_signed"}, bus.mul_signed, 0);
        check({tag, "_x"},      bus.mul_x, 0);
        check({tag, "_y"},      bus.mul_y, 0);
        check({tag, "_wbv"},    bus.wb_valid, 0);
        check({tag, "_wbrd"},   bus.wb_rd, 0);
        check({tag, "_wbdata"}, bus.wb_data, 0);
        check({tag, "_busy"},   bus.busy_rd, 0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.wb_ready  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(posedge clk);
        rst_ni = 1'b1;

        // MULHU max*max, rd=5: result shows up exactly 6 negedges after accept
        cycle(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 1'b0);
        idle(5, 1'b0);
        check("mulhu_early", bus.wb_valid, 1'b0);
        idle(1, 1'b0);
        check("mulhu_data", bus.wb_data, 32'hFFFF_FFFE);
        check("mulhu_rd",   bus.wb_rd, 5'd5);
        check("mulhu_busy", bus.busy_rd[5], 1'b1);
        idle(1, 1'b1);
        check("mulhu_busy_clr", bus.busy_rd, 32'd0);

        // MULH then MUL with the same operands
        cycle(1'b1, 2'd1, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1, 1'b0);
        check("mulh_signed", bus.mul_signed, 1'b1);
        cycle(1'b1, 2'd0, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1, 1'b0);
        idle(9, 1'b1);

        // MULHSU correction cases
        cycle(1'b1, 2'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 32'h7FFF_FFFF, 32'd4, 5'd9, 1'b0, 1'b0);
        idle(5, 1'b0);
        check("mulhsu_neg", bus.wb_data, 32'hFFFF_FFFF);
        idle(1, 1'b1);
        check("mulhsu_pos", bus.wb_data, 32'h0000_0001);
        idle(3, 1'b1);

        // credit limit with writeback blocked
        for (int i = 0; i < 6; i++)
            issue_hold(2'd0, 32'd100 + i, 32'd3, 5'd10 + 5'(i), 1'b0, 2);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b0, 1'b0);
        issue_hold(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b1, 4);
        issue_hold(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd17, 1'b1, 4);
        idle(14, 1'b1);

        // flush two cycles after three accepts
        cycle(1'b1, 2'd0, 32'd7, 32'd9, 5'd21, 1'b1, 1'b0);
        cycle(1'b1, 2'd3, 32'd7, 32'd9, 5'd22, 1'b1, 1'b0);
        cycle(1'b1, 2'd1, 32'd7, 32'd9, 5'd23, 1'b1, 1'b0);
        idle(2, 1'b1);
        cycle(1'b1, 2'd0, 32'd1, 32'd1, 5'd24, 1'b1, 1'b1);
        check("flush_busy", bus.busy_rd, 32'd0);
        check("flush_wbv",  bus.wb_valid, 1'b0);
        idle(8, 1'b1);
        cycle(1'b1, 2'd0, 32'd3, 32'd5, 5'd21, 1'b0, 1'b0);
        idle(6, 1'b0);
        check("post_flush", bus.wb_data, 32'd15);
        idle(2, 1'b1);

        // rd=0 op frees its credit without writeback
        cycle(1'b1, 2'd0, 32'd11, 32'd13, 5'd0, 1'b1, 1'b0);
        idle(8, 1'b1);

        // WAW stall on a repeated rd until the pop
        cycle(1'b1, 2'd0, 32'd5, 32'd6, 5'd9, 1'b0, 1'b0);
        idle(7, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 2'd0, 32'd8, 32'd8, 5'd9, 1'b0, 1'b0);
        issue_hold(2'd0, 32'd8, 32'd8, 5'd9, 1'b1, 4);
        idle(8, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        idle(12, 1'b1);

        // asynchronous reset while ops are in flight
        cycle(1'b1, 2'd0, 32'd2, 32'd3, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 32'd4, 32'd5, 5'd2, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 32'd6, 32'd7, 5'd3, 1'b0, 1'b0);
        idle(4, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("midreset");
        q.delete();
        e_start = 1'b0;
        e_sgn   = 1'b0;
        e_x     = '0;
        e_y     = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst_ni = 1'b1;
        idle(5, 1'b1);
        cycle(1'b1, 2'd2, 32'h8000_0000, 32'h0000_0003, 5'd4, 1'b1, 1'b0);
        idle(10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
